compare_tally: RTL and testbench
================================

# compare_tally

Downstream consumer of the two-bit comparator's outputs. Over a window of `WINDOW` valid comparison results it keeps saturating tallies of a-greater, b-greater and equal outcomes. It also detects a run of `STREAK_LEN` identical consecutive outcomes and flags malformed (non-one-hot) result vectors. Results are held stable after the window closes, until the next `start`.

## Interface
- `CNT_W`, 8: width of each tally counter; counters saturate at 2^CNT_W-1.
- `WINDOW`, 16: number of accepted samples per window; must be ≥1.
- `STREAK_LEN`, 4: consecutive identical outcomes needed to set `streak`; must be ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a new window; honoured only in IDLE.
- `in_valid` in 1: the comparator result on the three flag inputs is valid this cycle.
- `a_greater` in 1: comparator flag.
- `b_greater` in 1: comparator flag.
- `equal` in 1: comparator flag.
- `busy` out 1: high while in COUNT.
- `done` out 1: one-cycle pulse when the window completes.
- `a_count` out CNT_W: tally of a-greater outcomes.
- `b_count` out CNT_W: tally of b-greater outcomes.
- `eq_count` out CNT_W: tally of equal outcomes.
- `streak` out 1: sticky within a window; a streak of `STREAK_LEN` occurred.
- `streak_side` out 2: outcome of the first streak: 01 = a, 10 = b, 11 = equal, 00 = none.
- `onehot_err` out 1: sticky within a window; a malformed flag vector was seen.

## Operation
- FSM states are IDLE, COUNT and DONE. Reset state is IDLE. On reset, all outputs and internal counters are 0.
- IDLE:
  - `in_valid` is ignored.
  - On `start`, clear all tallies, the sample counter, the run counter and last-outcome, `streak`, `streak_side` and `onehot_err`, then go to COUNT.
- COUNT:
  - Each cycle with `in_valid`=1 is one accepted sample. Increment the sample counter, plus the matching tally, saturating at 2^CNT_W-1.
  - When the WINDOW-th sample is accepted, go to DONE.
  - `start` is ignored.
- DONE: lasts exactly one cycle with `done`=1, then returns to IDLE. `start` is ignored in this cycle.
- Tallies and flags hold from DONE until the next accepted `start`.
- Outcome decode: exactly one flag high gives that outcome. Any other pattern (none high, or two or more high) is a malformed sample:
  - It counts toward WINDOW.
  - It increments no tally.
  - It sets `onehot_err` (when enabled; see Configuration).
  - It resets the run counter to 0 and last-outcome to none.
- Streak tracking:
  - A sample whose outcome matches last-outcome increments the run counter.
  - A different outcome sets the run counter to 1.
  - Cycles with `in_valid`=0 do not break a run.
  - When the run counter reaches STREAK_LEN and `streak` is 0, set `streak` and latch `streak_side`.
  - Later streaks do not change `streak_side`.
- The sample counter is clog2(WINDOW+1) bits wide. The run counter saturates at STREAK_LEN.

## Timing
- All outputs are registered.
- A sample accepted on edge N is reflected in the tallies and flags after edge N.
- `start` sampled in IDLE on edge N gives `busy`=1 and cleared outputs from edge N onward.
- If the final sample is accepted on edge N, `busy` falls and `done`=1 after N. `done` falls after N+1.
- Minimum `start`-to-`done` time is WINDOW+1 edges, with `in_valid` held at 1.
- When `streak` is set by the final sample, it is visible in the same cycle as `done`.
- `rst` has priority over everything. Reset mid-window aborts the window: next cycle the block is in IDLE with all outputs 0.

## Configuration
- Macro: `COMPARE_TALLY_ONEHOT_CHECK_EN`.
- Defined: decode and malformed handling are exactly as described in Operation.
- Undefined:
  - `onehot_err` is tied to 0.
  - Decode is by priority: `a_greater`, else `b_greater`, else equal. An all-zero vector counts as equal.
  - No sample is ever treated as malformed.

## Test plan
- Reset: assert `rst` for 2 cycles in any state → all outputs 0, state IDLE. Pulse `in_valid` in IDLE → tallies stay 0.
- Basic window (WINDOW=4): `start`, then samples a, b, eq, a back-to-back → `done` pulses 5 edges after `start`; a=2, b=1, eq=1; `streak`=0.
- Streak with gaps (STREAK_LEN=3, WINDOW=6): samples b, idle, b, idle, b, a, a, a → `streak`=1 and `streak_side`=10, unchanged after the later a-run.
- Malformed vector with the macro defined: sample 110 mid-run of two a's, then a, a → `onehot_err`=1, `streak`=0 when STREAK_LEN=3. Without the macro: the 110 sample counts as a, `streak`=1 with side 01.
- Saturation (CNT_W=2, WINDOW=6): 6 a samples → `a_count`=3.
- Reset mid-window, and `start` while busy: a `start` pulse during COUNT is ignored, with the window length unchanged. `rst` after 2 of 4 samples → IDLE with zeros. A new `start` with 4 samples → fresh correct tallies.

Source files
------------

// File: rtl/compare_tally_if.sv
//==============================================================================
// compare_tally_if : comparator-result bus and tally result bus for compare_tally
// Revision: 1.0
//==============================================================================
`default_nettype none

interface compare_tally_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             in_valid;
  logic             a_greater;
  logic             b_greater;
  logic             equal;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;
  logic [CNT_W-1:0] eq_count;
  logic             streak;
  logic [1:0]       streak_side;
  logic             onehot_err;

  modport master (
    output start, in_valid, a_greater, b_greater, equal,
    input  busy, done, a_count, b_count, eq_count, streak, streak_side, onehot_err
  );

  modport slave (
    input  start, in_valid, a_greater, b_greater, equal,
    output busy, done, a_count, b_count, eq_count, streak, streak_side, onehot_err
  );
endinterface

`default_nettype wire

// File: rtl/compare_tally.sv
//==============================================================================
// compare_tally : windowed saturating tallies of comparator outcomes with
//                 streak detection and malformed-vector flag.
// Option macro  : COMPARE_TALLY_ONEHOT_CHECK_EN (strict one-hot decode + onehot_err)
// Revision      : 1.0
//==============================================================================
`default_nettype none

module compare_tally #(
  parameter int CNT_W      = 8,
  parameter int WINDOW     = 16,
  parameter int STREAK_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  compare_tally_if.slave     bus
);

  localparam int SAMP_W = $clog2(WINDOW + 1);
  localparam int RUN_W  = $clog2(STREAK_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_a_cnt, r_b_cnt, r_eq_cnt;
  logic [CNT_W-1:0]    w_a_nxt, w_b_nxt, w_eq_nxt;
  logic [SAMP_W-1:0]   r_samp, w_samp_nxt;
  logic [RUN_W-1:0]    r_run, w_run_nxt;
  logic [1:0]          r_last, w_last_nxt;
  logic                r_streak, w_streak_nxt;
  logic [1:0]          r_side, w_side_nxt;
  logic                r_err, w_err_nxt;
  logic                r_busy, r_done;

  // Outcome code doubles as the streak_side encoding: 01 a, 10 b, 11 equal.
  logic [1:0]          w_outcome;
  logic                w_bad;

  always_comb begin
    w_outcome = 2'b00;
    w_bad     = 1'b0;
`ifdef COMPARE_TALLY_ONEHOT_CHECK_EN
    case ({bus.a_greater, bus.b_greater, bus.equal})
      3'b100:  w_outcome = 2'b01;
      3'b010:  w_outcome = 2'b10;
      3'b001:  w_outcome = 2'b11;
      default: w_bad     = 1'b1;
    endcase
`else
    if (bus.a_greater)      w_outcome = 2'b01;
    else if (bus.b_greater) w_outcome = 2'b10;
    else                    w_outcome = 2'b11;
`endif
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a_cnt;
    w_b_nxt      = r_b_cnt;
    w_eq_nxt     = r_eq_cnt;
    w_samp_nxt   = r_samp;
    w_run_nxt    = r_run;
    w_last_nxt   = r_last;
    w_streak_nxt = r_streak;
    w_side_nxt   = r_side;
    w_err_nxt    = r_err;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_nxt      = '0;
          w_b_nxt      = '0;
          w_eq_nxt     = '0;
          w_samp_nxt   = '0;
          w_run_nxt    = '0;
          w_last_nxt   = 2'b00;
          w_streak_nxt = 1'b0;
          w_side_nxt   = 2'b00;
          w_err_nxt    = 1'b0;
          w_state_nxt  = S_COUNT;
        end
      end

      S_COUNT: begin
        if (bus.in_valid) begin
          w_samp_nxt = r_samp + SAMP_W'(1);
          if (w_bad) begin
            w_err_nxt  = 1'b1;
            w_run_nxt  = '0;
            w_last_nxt = 2'b00;
          end else begin
            case (w_outcome)
              2'b01:   w_a_nxt  = (r_a_cnt  == '1) ? r_a_cnt  : r_a_cnt  + CNT_W'(1);
              2'b10:   w_b_nxt  = (r_b_cnt  == '1) ? r_b_cnt  : r_b_cnt  + CNT_W'(1);
              default: w_eq_nxt = (r_eq_cnt == '1) ? r_eq_cnt : r_eq_cnt + CNT_W'(1);
            endcase
            // last-outcome of 00 never matches a valid outcome, so a run restarts at 1.
            if (w_outcome == r_last)
              w_run_nxt = (r_run == RUN_W'(STREAK_LEN)) ? r_run : r_run + RUN_W'(1);
            else
              w_run_nxt = RUN_W'(1);
            w_last_nxt = w_outcome;
            if (!r_streak && (w_run_nxt == RUN_W'(STREAK_LEN))) begin
              w_streak_nxt = 1'b1;
              w_side_nxt   = w_outcome;
            end
          end
          if (w_samp_nxt == SAMP_W'(WINDOW))
            w_state_nxt = S_DONE;
        end
      end

      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a_cnt  <= '0;
      r_b_cnt  <= '0;
      r_eq_cnt <= '0;
      r_samp   <= '0;
      r_run    <= '0;
      r_last   <= 2'b00;
      r_streak <= 1'b0;
      r_side   <= 2'b00;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_a_cnt  <= w_a_nxt;
      r_b_cnt  <= w_b_nxt;
      r_eq_cnt <= w_eq_nxt;
      r_samp   <= w_samp_nxt;
      r_run    <= w_run_nxt;
      r_last   <= w_last_nxt;
      r_streak <= w_streak_nxt;
      r_side   <= w_side_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= (w_state_nxt == S_COUNT);
      r_done   <= (w_state_nxt == S_DONE);
    end
  end

  // Without the one-hot check w_bad is constant 0, so r_err never leaves 0.
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.a_count     = r_a_cnt;
  assign bus.b_count     = r_b_cnt;
  assign bus.eq_count    = r_eq_cnt;
  assign bus.streak      = r_streak;
  assign bus.streak_side = r_side;
  assign bus.onehot_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_compare_tally.sv
//==============================================================================
// tb_compare_tally : table vectors, corner sequences and randomized windows
//                    checked against a list-based reference model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_compare_tally;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  compare_tally_if #(.CNT_W(8)) if1 ();
  compare_tally_if #(.CNT_W(2)) if2 ();

  compare_tally #(.CNT_W(8), .WINDOW(4), .STREAK_LEN(3)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  compare_tally #(.CNT_W(2), .WINDOW(6), .STREAK_LEN(3)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  // entry = {start, in_valid, a_greater, b_greater, equal}
  localparam logic [4:0] SA  = 5'b01100;
  localparam logic [4:0] SB  = 5'b01010;
  localparam logic [4:0] SE  = 5'b01001;
  localparam logic [4:0] SI  = 5'b00000;
  localparam logic [4:0] SZ  = 5'b01000;
  localparam logic [4:0] SAB = 5'b01110;
  localparam logic [4:0] SSB = 5'b11010;
  localparam int         STREAK = 3;

  typedef struct {
    int           sel;
    int           n;
    logic [159:0] s;
    logic [7:0]   ea, eb, eq;
    logic         es;
    logic [1:0]   side;
    logic         err;
    string        tag;
  } vec_t;

  typedef struct {
    logic       busy, done;
    logic [7:0] a, b, e;
    logic       streak;
    logic [1:0] side;
    logic       err;
  } out_t;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int sel, input logic [4:0] e);
    if (sel == 0) begin
      if1.start = e[4]; if1.in_valid = e[3];
      if1.a_greater = e[2]; if1.b_greater = e[1]; if1.equal = e[0];
    end else begin
      if2.start = e[4]; if2.in_valid = e[3];
      if2.a_greater = e[2]; if2.b_greater = e[1]; if2.equal = e[0];
    end
  endtask

  function automatic out_t rd(input int sel);
    out_t o;
    if (sel == 0) begin
      o.busy = if1.busy; o.done = if1.done;
      o.a = if1.a_count; o.b = if1.b_count; o.e = if1.eq_count;
      o.streak = if1.streak; o.side = if1.streak_side; o.err = if1.onehot_err;
    end else begin
      o.busy = if2.busy; o.done = if2.done;
      o.a = {6'b0, if2.a_count}; o.b = {6'b0, if2.b_count}; o.e = {6'b0, if2.eq_count};
      o.streak = if2.streak; o.side = if2.streak_side; o.err = if2.onehot_err;
    end
    return o;
  endfunction

  task automatic check_all(input int sel, input string tag, input logic ebusy, input logic edone,
                           input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] eq,
                           input logic es, input logic [1:0] eside, input logic eerr);
    out_t o = rd(sel);
    chk({tag, " busy"},   o.busy,   ebusy);
    chk({tag, " done"},   o.done,   edone);
    chk({tag, " a_cnt"},  o.a,      ea);
    chk({tag, " b_cnt"},  o.b,      eb);
    chk({tag, " eq_cnt"}, o.e,      eq);
    chk({tag, " streak"}, o.streak, es);
    chk({tag, " side"},   o.side,   eside);
    chk({tag, " err"},    o.err,    eerr);
  endtask

  // Entries are stored first-sample-at-MSB within the low n*5 bits.
  task automatic run_seq(input int sel, input int n, input logic [159:0] s,
                         input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] eq,
                         input logic es, input logic [1:0] eside, input logic eerr,
                         input string tag);
    out_t o;
    drv(sel, 5'b10000);
    step();
    check_all(sel, {tag, " cleared"}, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 1'b0);
    for (int i = 0; i < n; i++) begin
      drv(sel, s[5*(n-1-i) +: 5]);
      step();
      if (i < n - 1) begin
        o = rd(sel);
        chk({tag, " early done"}, {o.busy, o.done}, 2'b10);
      end
    end
    drv(sel, SI);
    check_all(sel, {tag, " done"}, 1'b0, 1'b1, ea, eb, eq, es, eside, eerr);
    step();
    check_all(sel, {tag, " hold"}, 1'b0, 1'b0, ea, eb, eq, es, eside, eerr);
  endtask

  function automatic int decode(input logic [2:0] f);
`ifdef COMPARE_TALLY_ONEHOT_CHECK_EN
    if (f == 3'b100) return 1;
    if (f == 3'b010) return 2;
    if (f == 3'b001) return 3;
    return 0;
`else
    if (f[2]) return 1;
    if (f[1]) return 2;
    return 3;
`endif
  endfunction

  // Reference: list of accepted outcomes, counted and scanned for runs.
  task automatic model(input int sel, input int n, input logic [159:0] s,
                       output logic [7:0] ea, output logic [7:0] eb, output logic [7:0] eq,
                       output logic es, output logic [1:0] eside, output logic eerr);
    int outs[$];
    int cmax = (sel == 0) ? 255 : 3;
    int cnt[4] = '{0, 0, 0, 0};
    logic [4:0] e;
    bit same;
    eerr = 1'b0; es = 1'b0; eside = 2'b00;
    for (int i = 0; i < n; i++) begin
      e = s[5*(n-1-i) +: 5];
      if (e[3]) outs.push_back(decode(e[2:0]));
    end
    foreach (outs[i]) begin
      cnt[outs[i]]++;
      if (outs[i] == 0) eerr = 1'b1;
    end
    ea = 8'((cnt[1] > cmax) ? cmax : cnt[1]);
    eb = 8'((cnt[2] > cmax) ? cmax : cnt[2]);
    eq = 8'((cnt[3] > cmax) ? cmax : cnt[3]);
    for (int i = STREAK - 1; i < outs.size(); i++) begin
      if (!es) begin
        same = (outs[i] != 0);
        for (int k = 1; k < STREAK; k++)
          if (outs[i-k] != outs[i]) same = 0;
        if (same) begin
          es = 1'b1;
          eside = 2'(outs[i]);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [159:0] s;
    logic [7:0]   ea, eb, eq;
    logic         es, eerr, st, v;
    logic [1:0]   eside;
    logic [2:0]   f;
    int           sel, win, n, nv, r;

    drv(0, SI);
    drv(1, SI);
    step();
    step();
    check_all(0, "reset0", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 1'b0);
    check_all(1, "reset1", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 1'b0);
    rst = 1'b0;

    drv(0, SA);
    step();
    drv(0, SI);
    step();
    check_all(0, "idle_valid", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 1'b0);

    tbl[0] = '{0, 4, 160'({SA, SB, SE, SA}), 8'd2, 8'd1, 8'd1, 1'b0, 2'b00, 1'b0, "basic"};
    tbl[1] = '{1, 8, 160'({SB, SI, SB, SI, SB, SA, SA, SA}), 8'd3, 8'd3, 8'd0, 1'b1, 2'b10, 1'b0, "streak_gap"};
`ifdef COMPARE_TALLY_ONEHOT_CHECK_EN
    tbl[2] = '{1, 6, 160'({SA, SA, SAB, SA, SA, SE}), 8'd3, 8'd0, 8'd1, 1'b0, 2'b00, 1'b1, "malformed"};
    tbl[5] = '{0, 4, 160'({SZ, SZ, SZ, SE}), 8'd0, 8'd0, 8'd1, 1'b0, 2'b00, 1'b1, "all_zero"};
`else
    tbl[2] = '{1, 6, 160'({SA, SA, SAB, SA, SA, SE}), 8'd3, 8'd0, 8'd1, 1'b1, 2'b01, 1'b0, "malformed"};
    tbl[5] = '{0, 4, 160'({SZ, SZ, SZ, SE}), 8'd0, 8'd0, 8'd4, 1'b1, 2'b11, 1'b0, "all_zero"};
`endif
    tbl[3] = '{1, 6, 160'({SA, SA, SA, SA, SA, SA}), 8'd3, 8'd0, 8'd0, 1'b1, 2'b01, 1'b0, "saturate"};
    tbl[4] = '{0, 4, 160'({SA, SSB, SE, SE}), 8'd1, 8'd1, 8'd2, 1'b0, 2'b00, 1'b0, "start_busy"};
    tbl[6] = '{0, 4, 160'({SE, SE, SE, SB}), 8'd0, 8'd1, 8'd3, 1'b1, 2'b11, 1'b0, "eq_streak"};

    for (int t = 0; t < 7; t++)
      run_seq(tbl[t].sel, tbl[t].n, tbl[t].s, tbl[t].ea, tbl[t].eb, tbl[t].eq,
              tbl[t].es, tbl[t].side, tbl[t].err, tbl[t].tag);

    // Abort a window with rst after two samples, then run a fresh one.
    drv(0, 5'b10000);
    step();
    drv(0, SA);
    step();
    drv(0, SB);
    step();
    drv(0, SI);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all(0, "mid_reset", 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0, 2'b00, 1'b0);
    run_seq(0, 4, 160'({SA, SA, SA, SB}), 8'd3, 8'd1, 8'd0, 1'b1, 2'b01, 1'b0, "after_reset");

    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom % 2);
      win = (sel == 0) ? 4 : 6;
      s = '0; n = 0; nv = 0;
      while (nv < win) begin
        v  = (n >= 24) || ($urandom % 4 != 0);
        st = ($urandom % 6 == 0);
        r  = int'($urandom % 8);
        if (r < 3)      f = 3'b100;
        else if (r < 5) f = 3'b010;
        else if (r < 7) f = 3'b001;
        else            f = 3'($urandom % 8);
        s = {s[154:0], st, v, f};
        n++;
        if (v) nv++;
      end
      model(sel, n, s, ea, eb, eq, es, eside, eerr);
      run_seq(sel, n, s, ea, eb, eq, es, eside, eerr, $sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
